// File: rtl/id_fetch_queue.sv
// IF->ID instruction queue: a circular buffer that takes up to IN_W fetched instructions per cycle
// and presents the oldest OUT_W entries to decode, with pre-sliced register/immediate fields.

module id_fq_slot #(
  parameter int EXC_W = 8
) (
  input  logic             valid,
  input  logic [31:0]      raw_instr,
  input  logic [31:0]      raw_pc,
  input  logic [EXC_W-1:0] raw_exc,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [EXC_W-1:0] exc,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm16
);
  // Empty slots read stale RAM, so every field is forced to zero.
  always_comb begin
    instr = '0;
    pc    = '0;
    exc   = '0;
    if (valid) begin
      instr = raw_instr;
      pc    = raw_pc;
      exc   = raw_exc;
    end
    rs    = instr[25:21];
    rt    = instr[20:16];
    rd    = instr[15:11];
    imm16 = instr[15:0];
  end
endmodule

module id_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2,
  parameter int EXC_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [IN_W-1:0]                  in_valid,
  input  logic [IN_W-1:0][31:0]            in_instr,
  input  logic [IN_W-1:0][31:0]            in_pc,
  input  logic [IN_W-1:0][EXC_W-1:0]       in_exc,
  output logic                             in_ready,
  input  logic [$clog2(OUT_W+1)-1:0]       out_pop,
  output logic [OUT_W-1:0]                 out_valid,
  output logic [OUT_W-1:0][31:0]           out_instr,
  output logic [OUT_W-1:0][31:0]           out_pc,
  output logic [OUT_W-1:0][EXC_W-1:0]      out_exc,
  output logic [OUT_W-1:0][4:0]            out_rs,
  output logic [OUT_W-1:0][4:0]            out_rt,
  output logic [OUT_W-1:0][4:0]            out_rd,
  output logic [OUT_W-1:0][15:0]           out_imm16,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]      ram_instr [DEPTH];
  logic [31:0]      ram_pc    [DEPTH];
  logic [EXC_W-1:0] ram_exc   [DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] n_push, n_pop, pop_req;
  logic          run;

  // in_ready looks only at registered occupancy; pops this cycle never free space early.
  assign in_ready = (count <= CW'(DEPTH - IN_W));

  always_comb begin
    n_push = '0;
    run    = 1'b1;
    for (int j = 0; j < IN_W; j++) begin
      run = run & in_valid[j];
      if (run) n_push = n_push + CW'(1);
    end
    if (!in_ready) n_push = '0;
  end

  assign pop_req = CW'(out_pop);
  assign n_pop   = (pop_req > count) ? count : pop_req;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push);
      count <= count + n_push - n_pop;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int j = 0; j < IN_W; j++) begin
      if (rst && !flush && (CW'(j) < n_push)) begin
        ram_instr[tail + AW'(j)] <= in_instr[j];
        ram_pc[tail + AW'(j)]    <= in_pc[j];
        ram_exc[tail + AW'(j)]   <= in_exc[j];
      end
    end
  end

  for (genvar i = 0; i < OUT_W; i++) begin : g_slot
    logic [AW-1:0] rd_idx;
    assign rd_idx       = head + AW'(i);
    assign out_valid[i] = (count > CW'(i));
    id_fq_slot #(.EXC_W(EXC_W)) u_slot (
      .valid     (out_valid[i]),
      .raw_instr (ram_instr[rd_idx]),
      .raw_pc    (ram_pc[rd_idx]),
      .raw_exc   (ram_exc[rd_idx]),
      .instr     (out_instr[i]),
      .pc        (out_pc[i]),
      .exc       (out_exc[i]),
      .rs        (out_rs[i]),
      .rt        (out_rt[i]),
      .rd        (out_rd[i]),
      .imm16     (out_imm16[i])
    );
  end
endmodule

// File: tb/tb_id_fetch_queue.sv
// Bench for id_fetch_queue: a queue-based reference model updated each posedge and a negedge
// monitor comparing every output slot against it, plus directed checks at the corner cases.
module tb_id_fetch_queue;
  localparam int DEPTH = 8;
  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int EXC_W = 8;
  localparam int PW    = $clog2(OUT_W+1);
  localparam int CW    = $clog2(DEPTH+1);

  logic                        clk, rst, flush;
  logic [IN_W-1:0]             in_valid;
  logic [IN_W-1:0][31:0]       in_instr, in_pc;
  logic [IN_W-1:0][EXC_W-1:0]  in_exc;
  logic                        in_ready;
  logic [PW-1:0]               out_pop;
  logic [OUT_W-1:0]            out_valid;
  logic [OUT_W-1:0][31:0]      out_instr, out_pc;
  logic [OUT_W-1:0][EXC_W-1:0] out_exc;
  logic [OUT_W-1:0][4:0]       out_rs, out_rt, out_rd;
  logic [OUT_W-1:0][15:0]      out_imm16;
  logic [CW-1:0]               count;

  id_fetch_queue #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_exc(in_exc), .in_ready(in_ready), .out_pop(out_pop),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm16(out_imm16), .count(count)
  );

  typedef struct {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [EXC_W-1:0] exc;
  } ent_t;

  ent_t        mq[$];
  bit          mon_en = 0;
  int          tests = 0, fails = 0;
  logic [31:0] pcn = 32'h100;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int slot, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s slot%0d: got %0h expected %0h at %0t", nm, slot, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries, following the push/pop/flush rules.
  always @(posedge clk) begin
    int sz, np;
    bit rdy;
    if (!rst) begin
      mq.delete();
      mon_en = 1;
    end else if (flush) begin
      mq.delete();
    end else begin
      sz  = mq.size();
      rdy = (sz <= DEPTH - IN_W);
      np  = (int'(out_pop) > sz) ? sz : int'(out_pop);
      repeat (np) void'(mq.pop_front());
      if (rdy) begin
        for (int j = 0; j < IN_W; j++) begin
          if (!in_valid[j]) break;
          mq.push_back('{instr: in_instr[j], pc: in_pc[j], exc: in_exc[j]});
        end
      end
    end
  end

  // Monitor: every slot against the model's oldest entries, empty slots all zero.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 0, 64'(count), 64'(mq.size()));
      chk("in_ready", 0, 64'(in_ready), 64'(mq.size() <= DEPTH - IN_W));
      for (int i = 0; i < OUT_W; i++) begin
        ent_t e;
        bit   v;
        v = (i < mq.size());
        e = '{instr: 32'h0, pc: 32'h0, exc: '0};
        if (v) e = mq[i];
        chk("out_valid", i, 64'(out_valid[i]), 64'(v));
        chk("out_pc",    i, 64'(out_pc[i]),    64'(e.pc));
        chk("out_instr", i, 64'(out_instr[i]), 64'(e.instr));
        chk("out_exc",   i, 64'(out_exc[i]),   64'(e.exc));
        chk("out_rs",    i, 64'(out_rs[i]),    64'(e.instr[25:21]));
        chk("out_rt",    i, 64'(out_rt[i]),    64'(e.instr[20:16]));
        chk("out_rd",    i, 64'(out_rd[i]),    64'(e.instr[15:11]));
        chk("out_imm16", i, 64'(out_imm16[i]), 64'(e.instr[15:0]));
      end
    end
  end

  // Drives one cycle of inputs at a negedge and returns at the next negedge.
  task automatic cyc(input bit r, input bit f, input logic [IN_W-1:0] v, input int pop);
    rst      = r;
    flush    = f;
    in_valid = v;
    out_pop  = PW'(pop);
    for (int j = 0; j < IN_W; j++) begin
      in_pc[j]    = pcn + 32'(4 * j);
      in_instr[j] = $urandom;
      in_exc[j]   = EXC_W'($urandom);
    end
    pcn = pcn + 32'(4 * IN_W);
    @(negedge clk);
  endtask

  initial begin
    rst = 0; flush = 0; in_valid = '0; out_pop = '0;
    in_instr = '0; in_pc = '0; in_exc = '0;
    @(negedge clk);

    // Reset while pushing
    cyc(0, 0, 2'b11, 0);
    cyc(0, 0, 2'b11, 0);
    chk("reset_count", 0, 64'(count), 64'd0);
    chk("reset_ready", 0, 64'(in_ready), 64'd1);
    chk("reset_valid", 0, 64'(out_valid), 64'd0);

    // Fill to full with no pops
    pcn = 32'h100;
    repeat (6) cyc(1, 0, 2'b11, 0);
    chk("fill_count", 0, 64'(count), 64'd8);
    chk("fill_ready", 0, 64'(in_ready), 64'd0);
    chk("fill_head_pc", 0, 64'(out_pc[0]), 64'h100);

    // Steady push 2 / pop 2 across the wrap point
    repeat (20) cyc(1, 0, 2'b11, 2);
    chk("steady_count", 0, 64'(count), 64'd6);

    // Non-thermometer valid drops everything after the first zero
    cyc(1, 0, 2'b10, 0);
    chk("valid10_count", 0, 64'(count), 64'd6);
    cyc(1, 0, 2'b01, 0);
    chk("valid01_count", 0, 64'(count), 64'd7);

    // Over-pop clamps at the occupancy
    cyc(1, 1, 2'b00, 0);
    cyc(1, 0, 2'b01, 0);
    chk("one_count", 0, 64'(count), 64'd1);
    cyc(1, 0, 2'b00, 2);
    chk("overpop_count", 0, 64'(count), 64'd0);
    chk("overpop_valid", 0, 64'(out_valid), 64'd0);

    // Flush wins over a simultaneous push and pop
    cyc(1, 0, 2'b11, 0);
    cyc(1, 0, 2'b11, 0);
    cyc(1, 0, 2'b01, 0);
    chk("pre_flush_count", 0, 64'(count), 64'd5);
    cyc(1, 1, 2'b11, 2);
    chk("flush_count", 0, 64'(count), 64'd0);
    chk("flush_valid", 0, 64'(out_valid), 64'd0);
    pcn = 32'h200;
    cyc(1, 0, 2'b01, 0);
    chk("after_flush_pc", 0, 64'(out_pc[0]), 64'h200);
    chk("after_flush_count", 0, 64'(count), 64'd1);

    // Random traffic with occasional flush and reset
    repeat (500) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
          IN_W'($urandom), int'($urandom_range(0, (1 << PW) - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
